// File: rtl/xadc_sample_framer.sv
// Packs one left-justified XADC sample per enabled channel into a framed byte stream:
// SYNC, SEQ, then {channel, sample[11:8]} / sample[7:0] pairs in ascending channel order.
module xadc_sample_framer #(
    parameter int         NUM_CHANNELS  = 2,
    parameter int         ADC_BITS      = 12,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter bit         DROP_ON_STALL = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic [NUM_CHANNELS-1:0]    i_chan_mask,
    input  logic [NUM_CHANNELS-1:0]    i_s_tvalid,
    output logic [NUM_CHANNELS-1:0]    o_s_tready,
    input  logic [16*NUM_CHANNELS-1:0] i_s_tdata,
    output logic                       o_m_tvalid,
    input  logic                       i_m_tready,
    output logic [7:0]                 o_m_tdata,
    output logic                       o_m_tlast,
    output logic [15:0]                o_overrun_count
);

    localparam int          CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [11:0] SAMPLE_MASK = 12'hFFF << (12 - ADC_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        HI,
        LO
    } state_t;

    logic [11:0]             r_hold  [NUM_CHANNELS];
    logic [11:0]             r_frame [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_full;
    logic [NUM_CHANNELS-1:0] r_frame_mask;
    state_t                  r_state;
    logic [CH_W-1:0]         r_chan;
    logic [7:0]              r_seq;
    logic                    r_m_tvalid;
    logic [7:0]              r_m_tdata;
    logic                    r_m_tlast;
    logic [15:0]             r_overrun;

    logic [NUM_CHANNELS-1:0] w_hs_in;
    logic [NUM_CHANNELS-1:0] w_ovr;
    logic [4:0]              w_ovr_inc;
    logic [16:0]             w_ovr_sum;
    logic                    w_start;
    logic                    w_out_hs;
    logic [CH_W-1:0]         w_first;
    logic [CH_W-1:0]         w_next;
    logic                    w_has_next;
    logic [11:0]             w_cur_sample;
    logic [11:0]             w_next_sample;
    logic                    w_unused_lsbs;

    assign o_s_tready = DROP_ON_STALL ? {NUM_CHANNELS{1'b1}} : (~i_chan_mask | ~r_full);
    assign w_hs_in    = i_s_tvalid & o_s_tready;
    assign w_start    = (r_state == IDLE) && i_enable && (|i_chan_mask)
                        && ((r_full & i_chan_mask) == i_chan_mask);
    assign w_out_hs   = r_m_tvalid && i_m_tready;

    // A sample landing on a still-full channel is only an overrun if the frame snapshot isn't taking the old one.
    assign w_ovr     = w_start ? '0 : (w_hs_in & i_chan_mask & r_full);
    assign w_ovr_sum = 17'(r_overrun) + 17'(w_ovr_inc);

    assign w_cur_sample  = r_frame[r_chan];
    assign w_next_sample = r_frame[w_next];

    always_comb begin
        w_first       = '0;
        w_next        = '0;
        w_has_next    = 1'b0;
        w_ovr_inc     = '0;
        w_unused_lsbs = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (i_chan_mask[i]) begin
                w_first = CH_W'(i);
            end
            if (r_frame_mask[i] && (i > int'(r_chan))) begin
                w_next     = CH_W'(i);
                w_has_next = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_ovr_inc     = w_ovr_inc + 5'(w_ovr[i]);
            w_unused_lsbs = w_unused_lsbs ^ (^i_s_tdata[16*i +: 4]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_hs_in[i] && i_chan_mask[i]) begin
                    r_hold[i] <= i_s_tdata[16*i+4 +: 12] & SAMPLE_MASK;
                    r_full[i] <= 1'b1;
                end else if (w_start) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_frame_mask <= '0;
            r_chan       <= '0;
            r_seq        <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tlast    <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_frame[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            r_frame[i] <= r_hold[i];
                        end
                        r_frame_mask <= i_chan_mask;
                        r_chan       <= w_first;
                        r_state      <= SYNC;
                        r_m_tvalid   <= 1'b1;
                        r_m_tdata    <= SYNC_BYTE;
                        r_m_tlast    <= 1'b0;
                    end
                end
                SYNC: begin
                    if (w_out_hs) begin
                        r_state   <= SEQ;
                        r_m_tdata <= r_seq;
                    end
                end
                SEQ: begin
                    if (w_out_hs) begin
                        r_state   <= HI;
                        r_m_tdata <= {4'(r_chan), w_cur_sample[11:8]};
                    end
                end
                HI: begin
                    if (w_out_hs) begin
                        r_state   <= LO;
                        r_m_tdata <= w_cur_sample[7:0];
                        r_m_tlast <= !w_has_next;
                    end
                end
                LO: begin
                    if (w_out_hs) begin
                        if (w_has_next) begin
                            r_chan    <= w_next;
                            r_state   <= HI;
                            r_m_tdata <= {4'(w_next), w_next_sample[11:8]};
                            r_m_tlast <= 1'b0;
                        end else begin
                            r_state    <= IDLE;
                            r_m_tvalid <= 1'b0;
                            r_m_tdata  <= '0;
                            r_m_tlast  <= 1'b0;
                            r_seq      <= r_seq + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_m_tvalid      = r_m_tvalid;
    assign o_m_tdata       = r_m_tdata;
    assign o_m_tlast       = r_m_tlast;
    assign o_overrun_count = r_overrun;

endmodule

// File: doc/xadc_sample_framer.md
Name: xadc_sample_framer

Overview:
- Parameterised successor to the single-channel XADC-to-USB glue.
- Accepts N 16-bit AXIS sample streams from the XADC DRP adapter, one per monitored channel, left-justified 12-bit codes.
- Packs one sample from each enabled channel into a framed byte stream for the ft232h sys_axis sink.
- Disabled or stalled channels never block the adapter, and lost samples are counted.

Parameters:
- NUM_CHANNELS, 2, number of input sample streams (1..16).
- ADC_BITS, 12, significant bits per sample, taken from tdata[15 -: ADC_BITS] (≤12).
- SYNC_BYTE, 8'hA5, first byte of every frame.
- DROP_ON_STALL, 1, 1 = inputs always ready, newest sample overwrites and overrun counts; 0 = AXIS backpressure on enabled channels.

Ports:
- clk  in  1  single clock (sys_clk domain)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new frames to start
- chan_mask  in  NUM_CHANNELS  per-channel enable, sampled at frame start
- s_tvalid  in  NUM_CHANNELS  per-channel sample valid
- s_tready  out  NUM_CHANNELS  per-channel sample ready
- s_tdata  in  16*NUM_CHANNELS  channel i at [16*i +: 16]
- m_tvalid  out  1  output byte valid
- m_tready  in  1  output byte ready (from ft232h sys_axis)
- m_tdata  out  8  output byte
- m_tlast  out  1  last byte of frame
- overrun_count  out  16  saturating count of overwritten samples

Behaviour:

Reset (rst_n low, asynchronous):
- All holding full flags = 0.
- State = IDLE.
- m_tvalid = 0, m_tdata = 0, m_tlast = 0.
- Sequence counter = 0; overrun_count = 0.
- s_tready is combinational. It is 1 for masked-off channels, and for all channels when DROP_ON_STALL = 1. Otherwise it is !full[i].

Input holding:
- Per channel: a 12-bit holding register plus a full flag.
- Handshake on a masked-on channel: store tdata[15:4] and set full.
- Handshake on a masked-off channel: discard, no count.
- DROP_ON_STALL = 1, handshake while full and no snapshot that cycle: overwrite the register and increment overrun_count (saturates at 16'hFFFF).

Frame start (IDLE):
- Condition: enable = 1, chan_mask ≠ 0, and full = 1 for every masked-on channel.
- Snapshot all masked-on holding registers into frame registers and latch the mask.
- Clear those full flags and go to SYNC.
- Same-cycle input on a snapshotted channel: the new sample goes into the holding register, full stays 1, no overrun.
- chan_mask = 0: remain in IDLE indefinitely.

States (each output state drives m_tvalid = 1 and advances only on m_tvalid && m_tready):
- SYNC: m_tdata = SYNC_BYTE.
- SEQ: m_tdata = sequence counter.
- HI: m_tdata = {channel index[3:0], sample[11:8]}.
- LO: m_tdata = sample[7:0].
- HI/LO iterate latched-enabled channels in ascending index order.
- After the last LO: increment the sequence counter (8-bit, 255 wraps to 0) and return to IDLE.
- m_tlast = 1 only on the last LO byte.

Output rules:
- m_tdata and m_tlast are registered and held stable while m_tvalid && !m_tready.
- m_tvalid never drops without a handshake.

Latency and size:
- Last required sample accepted at cycle t: full visible at t+1, SYNC presented with m_tvalid at t+2.
- Frame length = 2 + 2·K bytes, where K = enabled channel count.
- 1 byte/cycle with m_tready held high.
- Back-to-back frames: one IDLE cycle between the m_tlast handshake and the next SYNC.

Mid-operation changes:
- enable deasserted mid-frame: the current frame completes, no new frame starts.
- chan_mask change mid-frame: affects the next frame only.
- Channels removed from the mask while full: full flag cleared at the next frame start without emission.

Test Plan:
- NUM_CHANNELS=2, mask=2'b11, ch0 tdata=16'h1230, ch1 tdata=16'hABC0, m_tready=1 -> bytes A5,00,01,23,1A,BC; m_tlast on BC; SYNC appears 2 cycles after the second sample accept.
- Same setup with m_tready toggling 1/0 every cycle, 3 frames -> identical byte content, SEQ = 00,01,02; m_tdata stable while stalled; no duplicated or skipped bytes.
- mask=2'b10, ch0 valid every cycle, ch1 one sample 16'h0FF0 -> ch0 s_tready stays 1, overrun_count=0; frame A5,00,10,FF with m_tlast on FF.
- DROP_ON_STALL=1, m_tready=0, ch0 five samples while full -> overrun_count=4 before release; the frame carries the newest sample; overrun_count saturates at FFFF after forced stall.
- DROP_ON_STALL=0, m_tready=0 -> s_tready[0]=0 after one accept; no overrun; releasing m_tready resumes with no data loss.
- Run 256 frames, then assert rst_n low mid-HI byte -> SEQ wraps 255->0; on reset m_tvalid=0 immediately, counters 0, and the next frame starts with A5,00.
